// File: rtl/tl_ad_queue_buffer.sv
// ============================================================================
// tl_ad_queue_buffer : TileLink-UL A/D decoupling FIFOs with in-flight cap
// Rev 1.0
// ============================================================================
`default_nettype none

module tl_ad_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_enq_allow,
    input  logic                     i_enq_valid,
    output logic                     o_enq_ready,
    input  logic [WIDTH-1:0]         i_enq_bits,
    output logic                     o_deq_valid,
    input  logic                     i_deq_ready,
    output logic [WIDTH-1:0]         o_deq_bits,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int c_PW = $clog2(DEPTH);
    localparam logic [c_PW-1:0] c_PTR_ONE = 1;
    localparam logic [c_PW:0]   c_CNT_ONE = 1;
    localparam logic [c_PW:0]   c_FULL    = (c_PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW:0]    r_count;
    logic             w_enq;
    logic             w_deq;

    // Full blocks enqueue even when a dequeue frees a slot this cycle
    assign o_enq_ready = i_enq_allow && (r_count != c_FULL);
    assign o_deq_valid = (r_count != '0);
    assign o_deq_bits  = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign w_enq       = i_enq_valid && o_enq_ready;
    assign w_deq       = o_deq_valid && i_deq_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= i_enq_bits;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_deq) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_enq && !w_deq)      r_count <= r_count + c_CNT_ONE;
            else if (!w_enq && w_deq) r_count <= r_count - c_CNT_ONE;
        end
    end
endmodule

module tl_ad_queue_buffer #(
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [3:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_out_a_ready,
    output logic        auto_out_a_valid,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_param,
    output logic [2:0]  auto_out_a_bits_size,
    output logic [3:0]  auto_out_a_bits_source,
    output logic [31:0] auto_out_a_bits_address,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    output logic        auto_out_a_bits_corrupt,
    output logic        auto_out_d_ready,
    input  logic        auto_out_d_valid,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [2:0]  auto_out_d_bits_size,
    input  logic [3:0]  auto_out_d_bits_source,
    input  logic        auto_out_d_bits_denied,
    input  logic        auto_out_d_bits_corrupt,
    input  logic [63:0] auto_out_d_bits_data,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [3:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_denied,
    output logic        auto_in_d_bits_corrupt,
    output logic [63:0] auto_in_d_bits_data
);
    localparam int c_A_W = 118;
    localparam int c_D_W = 76;

    logic                      r_run;
    logic [3:0]                r_inflight;
    logic [c_A_W-1:0]          w_a_enq_bits;
    logic [c_A_W-1:0]          w_a_deq_bits;
    logic [c_D_W-1:0]          w_d_enq_bits;
    logic [c_D_W-1:0]          w_d_deq_bits;
    logic [$clog2(A_DEPTH):0]  w_a_count;
    logic [$clog2(D_DEPTH):0]  w_d_count;
    logic                      w_limit_ok;
    logic                      w_a_out_fire;
    logic                      w_d_in_fire;

    assign w_a_enq_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                           auto_in_a_bits_data, auto_in_a_bits_corrupt};
    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data, auto_out_a_bits_corrupt} = w_a_deq_bits;
    assign w_d_enq_bits = {auto_out_d_bits_opcode, auto_out_d_bits_size, auto_out_d_bits_source,
                           auto_out_d_bits_denied, auto_out_d_bits_corrupt, auto_out_d_bits_data};
    assign {auto_in_d_bits_opcode, auto_in_d_bits_size, auto_in_d_bits_source,
            auto_in_d_bits_denied, auto_in_d_bits_corrupt, auto_in_d_bits_data} = w_d_deq_bits;

    // Queued A beats count against the cap so the FIFO never over-commits
    assign w_limit_ok   = (int'(r_inflight) + int'(w_a_count)) < MAX_INFLIGHT;
    assign w_a_out_fire = auto_out_a_valid && auto_out_a_ready;
    assign w_d_in_fire  = auto_in_d_valid && auto_in_d_ready;

    tl_ad_fifo #(.DEPTH(A_DEPTH), .WIDTH(c_A_W)) u_a_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_enq_allow (r_run && w_limit_ok),
        .i_enq_valid (auto_in_a_valid),
        .o_enq_ready (auto_in_a_ready),
        .i_enq_bits  (w_a_enq_bits),
        .o_deq_valid (auto_out_a_valid),
        .i_deq_ready (auto_out_a_ready),
        .o_deq_bits  (w_a_deq_bits),
        .o_count     (w_a_count)
    );

    tl_ad_fifo #(.DEPTH(D_DEPTH), .WIDTH(c_D_W)) u_d_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_enq_allow (r_run),
        .i_enq_valid (auto_out_d_valid),
        .o_enq_ready (auto_out_d_ready),
        .i_enq_bits  (w_d_enq_bits),
        .o_deq_valid (auto_in_d_valid),
        .i_deq_ready (auto_in_d_ready),
        .o_deq_bits  (w_d_deq_bits),
        .o_count     (w_d_count)
    );

    // r_run holds both readies low until the first edge after reset release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run      <= 1'b0;
            r_inflight <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_a_out_fire && !w_d_in_fire) begin
                if (r_inflight != 4'(MAX_INFLIGHT)) r_inflight <= r_inflight + 4'd1;
            end else if (!w_a_out_fire && w_d_in_fire) begin
                if (r_inflight != 4'd0) r_inflight <= r_inflight - 4'd1;
            end
        end
    end

`ifndef SYNTHESIS
    a_size_ok: assert property (@(posedge clock) disable iff (!reset)
        (auto_in_a_valid && auto_in_a_ready) |-> (auto_in_a_bits_size <= 3'd3));
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        !(w_d_in_fire && !w_a_out_fire && r_inflight == 4'd0));
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(w_a_out_fire && !w_d_in_fire && r_inflight == 4'(MAX_INFLIGHT)));
    a_d_count_ok: assert property (@(posedge clock) disable iff (!reset)
        int'(w_d_count) <= D_DEPTH);
`endif
endmodule

`default_nettype wire

// File: tb/tb_tl_ad_queue_buffer.sv
// ============================================================================
// tb_tl_ad_queue_buffer : directed table-driven bench for tl_ad_queue_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tl_ad_queue_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_a_ready, in_a_valid;
    logic [2:0]  in_a_opcode, in_a_param, in_a_size;
    logic [3:0]  in_a_source;
    logic [31:0] in_a_address;
    logic [7:0]  in_a_mask;
    logic [63:0] in_a_data;
    logic        in_a_corrupt;
    logic        out_a_ready, out_a_valid;
    logic [2:0]  out_a_opcode, out_a_param, out_a_size;
    logic [3:0]  out_a_source;
    logic [31:0] out_a_address;
    logic [7:0]  out_a_mask;
    logic [63:0] out_a_data;
    logic        out_a_corrupt;
    logic        out_d_ready, out_d_valid;
    logic [2:0]  out_d_opcode, out_d_size;
    logic [3:0]  out_d_source;
    logic        out_d_denied, out_d_corrupt;
    logic [63:0] out_d_data;
    logic        in_d_ready, in_d_valid;
    logic [2:0]  in_d_opcode, in_d_size;
    logic [3:0]  in_d_source;
    logic        in_d_denied, in_d_corrupt;
    logic [63:0] in_d_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    tl_ad_queue_buffer #(.A_DEPTH(2), .D_DEPTH(2), .MAX_INFLIGHT(8)) dut (
        .clock(clock), .reset(reset),
        .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid),
        .auto_in_a_bits_opcode(in_a_opcode), .auto_in_a_bits_param(in_a_param),
        .auto_in_a_bits_size(in_a_size), .auto_in_a_bits_source(in_a_source),
        .auto_in_a_bits_address(in_a_address), .auto_in_a_bits_mask(in_a_mask),
        .auto_in_a_bits_data(in_a_data), .auto_in_a_bits_corrupt(in_a_corrupt),
        .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
        .auto_out_a_bits_opcode(out_a_opcode), .auto_out_a_bits_param(out_a_param),
        .auto_out_a_bits_size(out_a_size), .auto_out_a_bits_source(out_a_source),
        .auto_out_a_bits_address(out_a_address), .auto_out_a_bits_mask(out_a_mask),
        .auto_out_a_bits_data(out_a_data), .auto_out_a_bits_corrupt(out_a_corrupt),
        .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
        .auto_out_d_bits_opcode(out_d_opcode), .auto_out_d_bits_size(out_d_size),
        .auto_out_d_bits_source(out_d_source), .auto_out_d_bits_denied(out_d_denied),
        .auto_out_d_bits_corrupt(out_d_corrupt), .auto_out_d_bits_data(out_d_data),
        .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
        .auto_in_d_bits_opcode(in_d_opcode), .auto_in_d_bits_size(in_d_size),
        .auto_in_d_bits_source(in_d_source), .auto_in_d_bits_denied(in_d_denied),
        .auto_in_d_bits_corrupt(in_d_corrupt), .auto_in_d_bits_data(in_d_data)
    );

    typedef struct {
        logic        a_valid;
        logic [63:0] a_data;
        logic        out_a_ready;
        logic        d_valid;
        logic [63:0] d_data;
        logic        in_d_ready;
        logic        exp_a_ready;
        logic        exp_a_valid;
        logic [63:0] exp_a_data;
        logic        exp_d_ready;
        logic        exp_d_valid;
        logic [63:0] exp_d_data;
        logic [3:0]  exp_inflight;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n_in;
        int n_out;
        in_a_valid = 0; in_a_opcode = 3'd4; in_a_param = 0; in_a_size = 3'd3;
        in_a_source = 4'h3; in_a_address = 32'h8000_0000; in_a_mask = 8'hFF;
        in_a_data = 0; in_a_corrupt = 0; out_a_ready = 0;
        out_d_valid = 0; out_d_opcode = 3'd1; out_d_size = 3'd3; out_d_source = 4'h3;
        out_d_denied = 0; out_d_corrupt = 0; out_d_data = 0; in_d_ready = 0;

        // a_v  a_data   oar  d_v  d_data   idr  ear  eav  ead      edr  edv  edd      inf
        vecs[0]  = '{1, 64'hA1, 0, 0, 64'h0,  0, 1, 0, 64'h0,  1, 0, 64'h0,  4'd0};
        vecs[1]  = '{1, 64'hA2, 0, 0, 64'h0,  0, 1, 1, 64'hA1, 1, 0, 64'h0,  4'd0};
        vecs[2]  = '{1, 64'hA3, 0, 0, 64'h0,  0, 0, 1, 64'hA1, 1, 0, 64'h0,  4'd0};
        vecs[3]  = '{0, 64'h0,  1, 0, 64'h0,  0, 0, 1, 64'hA1, 1, 0, 64'h0,  4'd0};
        vecs[4]  = '{0, 64'h0,  1, 0, 64'h0,  0, 1, 1, 64'hA2, 1, 0, 64'h0,  4'd1};
        vecs[5]  = '{0, 64'h0,  1, 0, 64'h0,  0, 1, 0, 64'h0,  1, 0, 64'h0,  4'd2};
        vecs[6]  = '{0, 64'h0,  0, 1, 64'hD1, 0, 1, 0, 64'h0,  1, 0, 64'h0,  4'd2};
        vecs[7]  = '{0, 64'h0,  0, 1, 64'hD2, 0, 1, 0, 64'h0,  1, 1, 64'hD1, 4'd2};
        vecs[8]  = '{0, 64'h0,  0, 1, 64'hD3, 0, 1, 0, 64'h0,  0, 1, 64'hD1, 4'd2};
        vecs[9]  = '{0, 64'h0,  0, 1, 64'hD3, 1, 1, 0, 64'h0,  0, 1, 64'hD1, 4'd2};
        vecs[10] = '{0, 64'h0,  0, 1, 64'hD3, 1, 1, 0, 64'h0,  1, 1, 64'hD2, 4'd1};
        vecs[11] = '{0, 64'h0,  0, 0, 64'h0,  0, 1, 0, 64'h0,  1, 1, 64'hD3, 4'd0};

        // Held in reset: everything idle
        tick(); tick();
        chk("rst_a_ready", in_a_ready, 0);
        chk("rst_d_ready", out_d_ready, 0);
        chk("rst_a_valid", out_a_valid, 0);
        chk("rst_d_valid", in_d_valid, 0);
        reset = 1;
        tick();
        chk("rel_a_ready", in_a_ready, 1);
        chk("rel_d_ready", out_d_ready, 1);
        chk("rel_a_valid", out_a_valid, 0);
        chk("rel_d_valid", in_d_valid, 0);

        // Single Get and its AccessAckData
        in_a_valid = 1; out_a_ready = 1;
        tick();
        in_a_valid = 0;
        chk("get_a_valid", out_a_valid, 1);
        chk("get_a_bits",
            {out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address,
             out_a_mask, out_a_data, out_a_corrupt},
            {3'd4, 3'd0, 3'd3, 4'h3, 32'h8000_0000, 8'hFF, 64'h0, 1'b0});
        tick();
        chk("get_a_gone", out_a_valid, 0);
        chk("get_inflight1", dut.r_inflight, 1);
        out_d_valid = 1; out_d_data = 64'hDEAD_BEEF_0123_4567; in_d_ready = 1;
        tick();
        out_d_valid = 0;
        chk("ack_d_valid", in_d_valid, 1);
        chk("ack_d_bits",
            {in_d_opcode, in_d_size, in_d_source, in_d_denied, in_d_corrupt, in_d_data},
            {3'd1, 3'd3, 4'h3, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567});
        tick();
        in_d_ready = 0;
        chk("ack_d_gone", in_d_valid, 0);
        chk("ack_inflight0", dut.r_inflight, 0);

        // A backpressure then D backpressure, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            in_a_valid = vecs[i].a_valid; in_a_data = vecs[i].a_data;
            out_a_ready = vecs[i].out_a_ready;
            out_d_valid = vecs[i].d_valid; out_d_data = vecs[i].d_data;
            in_d_ready = vecs[i].in_d_ready;
            chk($sformatf("v%0d_a_ready", i), in_a_ready, vecs[i].exp_a_ready);
            chk($sformatf("v%0d_a_valid", i), out_a_valid, vecs[i].exp_a_valid);
            if (vecs[i].exp_a_valid) chk($sformatf("v%0d_a_data", i), out_a_data, vecs[i].exp_a_data);
            chk($sformatf("v%0d_d_ready", i), out_d_ready, vecs[i].exp_d_ready);
            chk($sformatf("v%0d_d_valid", i), in_d_valid, vecs[i].exp_d_valid);
            if (vecs[i].exp_d_valid) chk($sformatf("v%0d_d_data", i), in_d_data, vecs[i].exp_d_data);
            chk($sformatf("v%0d_inflight", i), dut.r_inflight, vecs[i].exp_inflight);
            tick();
        end

        // Reset with two A and two D beats queued (D3 already waiting)
        in_a_valid = 1; in_a_data = 64'hB1; out_a_ready = 0;
        out_d_valid = 1; out_d_data = 64'hD4; in_d_ready = 0;
        tick();
        in_a_data = 64'hB2; out_d_valid = 0;
        tick();
        in_a_valid = 0;
        chk("q_a_valid", out_a_valid, 1);
        chk("q_a_full", in_a_ready, 0);
        chk("q_d_valid", in_d_valid, 1);
        chk("q_d_full", out_d_ready, 0);
        reset = 0;
        #1;
        chk("mid_rst_a_valid", out_a_valid, 0);
        chk("mid_rst_d_valid", in_d_valid, 0);
        chk("mid_rst_a_ready", in_a_ready, 0);
        chk("mid_rst_d_ready", out_d_ready, 0);
        tick();
        reset = 1;
        tick();
        chk("post_rst_a_valid", out_a_valid, 0);
        chk("post_rst_d_valid", in_d_valid, 0);
        chk("post_rst_a_ready", in_a_ready, 1);
        chk("post_rst_inflight", dut.r_inflight, 0);

        // In-flight cap: slave never answers
        n_in = 0; n_out = 0;
        in_a_valid = 1; out_a_ready = 1;
        for (int c = 0; c < 20; c++) begin
            if (in_a_valid && in_a_ready) n_in++;
            if (out_a_valid && out_a_ready) n_out++;
            tick();
        end
        chk("cap_out_beats", n_out, 8);
        chk("cap_in_beats", n_in, 8);
        chk("cap_a_ready", in_a_ready, 0);
        chk("cap_inflight", dut.r_inflight, 8);
        out_d_valid = 1; out_d_data = 64'h55;
        tick();
        out_d_valid = 0; in_d_ready = 1;
        chk("cap_d_valid", in_d_valid, 1);
        chk("cap_still_blocked", in_a_ready, 0);
        tick();
        in_d_ready = 0;
        chk("cap_reopen", in_a_ready, 1);
        chk("cap_inflight7", dut.r_inflight, 7);
        in_a_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
